fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that feeds the IF/ID register of the 5-stage pipelined core.
- Issues word-addressed reads to a synchronous instruction memory and buffers returned words with their NPC in a small FIFO.
- Hands words to decode over a valid/ready handshake.
- Handles taken-branch redirects (flush plus refetch) and the sticky halt raised by WB on HLT.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- ADDR_W, 10, instruction memory word-address width (1024 words).
- RESET_PC, 0, fetch address after reset.

Ports:
- clk1  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_rd_en  out  1  read request this cycle (combinational).
- imem_addr  out  ADDR_W  read word address = pc[ADDR_W-1:0] (combinational).
- imem_rdata  in  32  read data, valid the cycle after the request.
- redirect_valid  in  1  taken branch from EX/MEM; one-cycle pulse.
- redirect_pc  in  32  branch target word address.
- halt  in  1  HLT retired in WB; captured sticky.
- id_valid  out  1  head entry is available to decode.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_ir  out  32  head instruction; 0 when id_valid=0.
- id_npc  out  32  head address + 1; 0 when id_valid=0.
- pc  out  32  next fetch address.
- queue_count  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset values: pc=RESET_PC, queue empty, count=0, inflight=0, halted=0, id_valid=0, id_ir=0, id_npc=0, imem_rd_en=0 while rst=1.
- Reset mid-operation discards all entries and any in-flight read. The response arriving the cycle after reset deasserts is ignored.
- Issue condition: imem_rd_en = !rst && !halted && !redirect_valid && (count + inflight - pop) < DEPTH, where pop = id_valid && id_ready.
- On issue: inflight<=1 and tag<=pc at the edge, then pc<=pc+1 (32-bit wrap).
- Response: if inflight=1 and not killed, push {imem_rdata, tag+1} at the next edge. inflight clears unless a new read issues.
- Latency: first edge with rst=0 issues the read of RESET_PC. id_valid rises after the second edge. Sustained throughput is 1 word/cycle while id_ready=1.
- Same-cycle push and pop are legal at any occupancy, including full. The count is unchanged in that case.
- Pop on an empty queue is impossible because id_valid=0. id_ready is ignored when id_valid=0.
- Redirect takes priority over push, pop and issue in its cycle:
  - queue cleared, count<=0;
  - any in-flight response is dropped (kill flag);
  - pc<=redirect_pc; no read issued in the redirect cycle.
- After a redirect, the first read of redirect_pc issues on the next cycle. The target reaches id_valid 2 edges after that.
- Halt: halted<=1 at the edge where halt=1; stays set until rst. No further reads issue.
  - The queue still drains to decode.
  - A response already in flight is still pushed.
  - A redirect while halted still flushes and updates pc, but fetch stays stopped.
- Simultaneous halt and redirect: both take effect.
- queue_count never exceeds DEPTH. An overflow attempt is a design error; flag it with a simulation-only assertion.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds:
  - output stat_fetched [31:0]: increments on every pushed word;
  - output stat_flushed [31:0]: increments by the number of discarded entries plus the killed in-flight word on each redirect.
- Both counters clear on rst and wrap at 2^32.
- When not defined, neither port nor counter exists; the remaining behaviour is identical.

Test Plan:
- Reset release, memory holds word n at address n, id_ready=1 -> reads addr 0,1,2,...; id_valid high from the 2nd edge; id_ir=0,1,2,... with id_npc=1,2,3,...; one word per cycle.
- id_ready=0 for 10 cycles -> queue_count saturates at 4 (DEPTH); reads stop at addr 3 with none in flight beyond it. Set id_ready=1 -> words 0..3 are delivered in order with no loss or duplicate.
- Redirect pulse with redirect_pc=0x40 while queue_count=3 and a read is in flight -> queue_count=0 next cycle; old words never appear; next id_ir=mem[0x40] with id_npc=0x41.
- halt=1 while fetching with id_ready=1 -> no imem_rd_en after that edge; the in-flight word and queued words are still delivered; id_valid then stays 0 until rst.
- rst asserted with queue full and a read in flight -> all outputs return to reset values on the next edge; after release, fetch restarts at RESET_PC.
- With FETCH_STATS_EN: 5 words pushed, then a redirect with 2 queued plus 1 in flight -> stat_fetched=5, stat_flushed=3.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: word reads from a synchronous imem, prefetch FIFO to decode.
// Optional FETCH_STATS_EN adds fetched/flushed word counters.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                         clk1,
  input  logic                         rst,
  output logic                         imem_rd_en,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [31:0]                  id_ir,
  output logic [31:0]                  id_npc,
  output logic [31:0]                  pc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                  stat_fetched,
  output logic [31:0]                  stat_flushed
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic             halted_q, halted_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      ir_mem_q  [DEPTH];
  logic [31:0]      npc_mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W:0]   occ;

  // A redirect in the response cycle kills the in-flight word.
  assign push = inflight_q && !redirect_valid;
  assign pop  = id_valid && id_ready;

  // Occupancy after this edge if nothing new issues: queued + returning - leaving.
  assign occ = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

  assign imem_rd_en  = !rst && !halted_q && !redirect_valid && (occ < DEPTH_OCC);
  assign imem_addr   = pc_q[ADDR_W-1:0];
  assign pc          = pc_q;
  assign queue_count = count_q;

  assign id_valid = !rst && (count_q != '0);
  assign id_ir    = id_valid ? ir_mem_q[rd_ptr_q]  : 32'd0;
  assign id_npc   = id_valid ? npc_mem_q[rd_ptr_q] : 32'd0;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    halted_d   = halted_q || halt;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      inflight_d = imem_rd_en;
      if (imem_rd_en) begin
        tag_d = pc_q;
        pc_d  = pc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk1) begin
    if (!rst && push) begin
      ir_mem_q[wr_ptr_q]  <= imem_rdata;
      npc_mem_q[wr_ptr_q] <= tag_q + 32'd1;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_flushed_q;

  always_ff @(posedge clk1) begin
    if (rst) begin
      stat_fetched_q <= 32'd0;
      stat_flushed_q <= 32'd0;
    end else begin
      if (push) begin
        stat_fetched_q <= stat_fetched_q + 32'd1;
      end
      if (redirect_valid) begin
        stat_flushed_q <= stat_flushed_q + 32'(count_q) + 32'(inflight_q);
      end
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk1) begin
    if (!rst && push && !pop) begin
      assert (count_q < CNT_W'(DEPTH))
        else $error("fetch_prefetch_queue: push into full queue");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a transaction-level queue model.
// Builds with or without FETCH_STATS_EN.
module tb_fetch_prefetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_ir;
  logic [31:0]       id_npc;
  logic [31:0]       pc;
  logic [2:0]        queue_count;
`ifdef FETCH_STATS_EN
  logic [31:0]       stat_fetched;
  logic [31:0]       stat_flushed;
`endif

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'd0)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_ir          (id_ir),
    .id_npc         (id_npc),
    .pc             (pc),
`ifdef FETCH_STATS_EN
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed),
`endif
    .queue_count    (queue_count)
  );

  always #5 clk1 = ~clk1;

  // Distinct word per address so misordered or stale words are visible.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a, 12'hA5C, a};
  endfunction

  always @(posedge clk1) imem_rdata <= mem_word(imem_addr);

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the prefetch queue as a list of {ir, npc}, plus the fetch pointer
  // and the single outstanding read.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  bit          m_inflight;
  bit          m_halted;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  task automatic model_reset();
    m_q.delete();
    m_pc       = 32'd0;
    m_tag      = 32'd0;
    m_inflight = 1'b0;
    m_halted   = 1'b0;
    m_fetched  = 32'd0;
    m_flushed  = 32'd0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model
  // to what the coming rising edge should produce.
  task automatic step(input bit r, input bit rdy, input bit redir, input logic [31:0] rpc,
                      input bit hlt);
    int          occ;
    bit          pop;
    bit          issue;
    bit          valid;
    logic [63:0] head;
    @(negedge clk1);
    rst            = r;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    halt           = hlt;
    #1;
    valid = !r && (m_q.size() > 0);
    pop   = valid && rdy;
    occ   = m_q.size() + int'(m_inflight) - int'(pop);
    issue = !r && !m_halted && !redir && (occ < DEPTH);
    head  = valid ? m_q[0] : 64'd0;

    check_eq("rd_en", 32'(imem_rd_en), 32'(issue));
    if (issue) check_eq("imem_addr", 32'(imem_addr), 32'(m_pc[ADDR_W-1:0]));
    check_eq("id_valid", 32'(id_valid), 32'(valid));
    check_eq("id_ir", id_ir, head[63:32]);
    check_eq("id_npc", id_npc, head[31:0]);
    check_eq("pc", pc, m_pc);
    check_eq("queue_count", 32'(queue_count), 32'(m_q.size()));
`ifdef FETCH_STATS_EN
    check_eq("stat_fetched", stat_fetched, m_fetched);
    check_eq("stat_flushed", stat_flushed, m_flushed);
`endif

    if (r) begin
      model_reset();
    end else begin
      if (redir) begin
        m_flushed  = m_flushed + 32'(m_q.size()) + 32'(m_inflight);
        m_q.delete();
        m_inflight = 1'b0;
        m_pc       = rpc;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_inflight) begin
          m_q.push_back({mem_word(m_tag[ADDR_W-1:0]), m_tag + 32'd1});
          m_fetched = m_fetched + 32'd1;
        end
        if (issue) begin
          m_tag = m_pc;
          m_pc  = m_pc + 32'd1;
        end
        m_inflight = issue;
      end
      if (hlt) m_halted = 1'b1;
    end
  endtask

  initial begin
    rst            = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    repeat (2) @(posedge clk1);
    model_reset();

    // Reset values, then streaming with decode always ready.
    repeat (2) step(1, 0, 0, 32'd0, 0);
    repeat (8) step(0, 1, 0, 32'd0, 0);

    // Decode stalled: the queue fills to DEPTH and fetch stops.
    repeat (10) step(0, 0, 0, 32'd0, 0);
    check_eq("sat_count", 32'(queue_count), 32'(DEPTH));
    check_eq("sat_rd_en", 32'(imem_rd_en), 32'd0);
    repeat (6) step(0, 1, 0, 32'd0, 0);

    // Redirect with three queued and one in flight.
    for (int i = 0; i < 12 && !(m_q.size() == 3 && m_inflight); i++) step(0, 0, 0, 32'd0, 0);
    check_eq("pre_redir_count", 32'(queue_count), 32'd3);
    step(0, 0, 1, 32'h40, 0);
    step(0, 1, 0, 32'd0, 0);
    check_eq("post_redir_count", 32'(queue_count), 32'd0);
    repeat (2) step(0, 1, 0, 32'd0, 0);
    check_eq("redir_ir", id_ir, mem_word(10'h40));
    check_eq("redir_npc", id_npc, 32'h41);
    repeat (4) step(0, 1, 0, 32'd0, 0);

    // Halt while streaming: drain, then nothing more; redirect still updates pc.
    step(0, 1, 0, 32'd0, 1);
    repeat (8) step(0, 1, 0, 32'd0, 0);
    check_eq("halted_valid", 32'(id_valid), 32'd0);
    step(0, 1, 1, 32'h123, 0);
    repeat (3) step(0, 1, 0, 32'd0, 0);
    check_eq("halted_pc", pc, 32'h123);

    // Reset with a loaded queue and a read in flight.
    step(1, 0, 0, 32'd0, 0);
    for (int i = 0; i < 12 && !(m_q.size() == 3 && m_inflight); i++) step(0, 0, 0, 32'd0, 0);
    step(1, 0, 0, 32'd0, 0);
    step(0, 1, 0, 32'd0, 0);
    check_eq("rst_pc", pc, 32'd0);
    repeat (4) step(0, 1, 0, 32'd0, 0);

    // Random traffic.
    repeat (3000) begin
      step(($urandom % 128) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0, $urandom,
           ($urandom % 256) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
